// File: rtl/bf16_pkg.sv
// bf16_pkg: shared bfloat16 field widths, special encodings, error codes,
// the sticky error-merge function and the accumulator FSM state type.
package bf16_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 7;
  localparam int BIAS  = 127;

  localparam logic [15:0] BF16_POS_INF = 16'h7F80;
  localparam logic [15:0] BF16_NEG_INF = 16'hFF80;
  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [15:0] BF16_MAX     = 16'h7F7F;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;
  localparam logic [1:0] ERR_INV  = 2'd3;

  typedef logic [0:0] state_t;
  localparam state_t ST_ACCUM = 1'b0;
  localparam state_t ST_HOLD  = 1'b1;

  // Sticky merge, severity INV > OVF > UNF > NONE.
  function automatic logic [1:0] err_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == ERR_INV || b == ERR_INV) return ERR_INV;
    if (a == ERR_OVF || b == ERR_OVF) return ERR_OVF;
    if (a == ERR_UNF || b == ERR_UNF) return ERR_UNF;
    return ERR_NONE;
  endfunction
endpackage

// File: rtl/bf16_add.sv
// bf16_add: combinational bfloat16 adder, round-to-nearest-even.
// Ports: i_a, i_b (operands), o_sum (result), o_err (0 none, 1 ovf, 2 unf, 3 inv).
// Subnormal inputs read as zero; subnormal results flush to signed zero.
// Macro BF16_MUL_ACC_SATURATE_EN: overflow yields signed max finite instead of inf.
module bf16_add
  import bf16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum,
  output logic [1:0]  o_err
);
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sub;
  logic              w_swap;
  logic [15:0]       w_big, w_sml;
  logic [EXP_W-1:0]  w_d;
  logic [3:0]        w_sh, w_lz;
  // 11-bit working mantissa: hidden bit, 7 fraction bits, guard, round, sticky
  logic [10:0]       w_mb, w_ms, w_mask, w_al, w_diff, w_n;
  logic [11:0]       w_sum12;
  logic signed [9:0] w_e;
  logic              w_rup;
  logic [8:0]        w_m9;
  logic [MAN_W-1:0]  w_man;

  assign w_a_zero = (i_a[14:7] == 8'd0);
  assign w_b_zero = (i_b[14:7] == 8'd0);
  assign w_a_inf  = (i_a[14:7] == 8'hFF) && (i_a[6:0] == 7'd0);
  assign w_b_inf  = (i_b[14:7] == 8'hFF) && (i_b[6:0] == 7'd0);
  assign w_a_nan  = (i_a[14:7] == 8'hFF) && (i_a[6:0] != 7'd0);
  assign w_b_nan  = (i_b[14:7] == 8'hFF) && (i_b[6:0] != 7'd0);
  assign w_sub    = i_a[15] ^ i_b[15];

  // Larger magnitude first so the subtract path never goes negative.
  assign w_swap = i_b[14:0] > i_a[14:0];
  assign w_big  = w_swap ? i_b : i_a;
  assign w_sml  = w_swap ? i_a : i_b;
  assign w_d    = w_big[14:7] - w_sml[14:7];
  // Beyond 11 places the whole small mantissa lands in sticky.
  assign w_sh   = (w_d > 8'd11) ? 4'd11 : w_d[3:0];
  assign w_mb   = {1'b1, w_big[6:0], 3'b000};
  assign w_ms   = {1'b1, w_sml[6:0], 3'b000};
  assign w_mask = (11'd1 << w_sh) - 11'd1;
  assign w_al   = (w_ms >> w_sh) | {10'd0, |(w_ms & w_mask)};

  assign w_sum12 = {1'b0, w_mb} + {1'b0, w_al};
  assign w_diff  = w_mb - w_al;

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 11; i++)
      if (w_diff[i]) w_lz = 4'(10 - i);
  end

  always_comb begin
    w_n   = '0;
    w_e   = '0;
    w_rup = 1'b0;
    w_m9  = '0;
    w_man = '0;
    o_sum = 16'h0000;
    o_err = ERR_NONE;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_sub)) begin
      o_sum = BF16_QNAN;
      o_err = ERR_INV;
    end else if (w_a_inf) begin
      o_sum = i_a;
    end else if (w_b_inf) begin
      o_sum = i_b;
    end else if (w_a_zero && w_b_zero) begin
      o_sum = {i_a[15] & i_b[15], 15'd0};
    end else if (w_a_zero) begin
      o_sum = i_b;
    end else if (w_b_zero) begin
      o_sum = i_a;
    end else if (w_sub && (w_diff == 11'd0)) begin
      o_sum = 16'h0000;   // exact cancellation is +0
    end else begin
      if (!w_sub) begin
        if (w_sum12[11]) begin
          w_n = {w_sum12[11:2], |w_sum12[1:0]};
          w_e = $signed({2'b00, w_big[14:7]}) + 10'sd1;
        end else begin
          w_n = w_sum12[10:0];
          w_e = $signed({2'b00, w_big[14:7]});
        end
      end else begin
        // Large left shifts only occur when alignment was <=1, so no sticky is lost.
        w_n = w_diff << w_lz;
        w_e = $signed({2'b00, w_big[14:7]}) - $signed({6'd0, w_lz});
      end
      w_rup = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
      w_m9  = {1'b0, w_n[10:3]} + {8'd0, w_rup};
      if (w_m9[8]) begin
        w_e   = w_e + 10'sd1;
        w_man = w_m9[7:1];
      end else begin
        w_man = w_m9[6:0];
      end
      if (w_e >= 10'sd255) begin
        o_err = ERR_OVF;
`ifdef BF16_MUL_ACC_SATURATE_EN
        o_sum = {w_big[15], BF16_MAX[14:0]};
`else
        o_sum = w_big[15] ? BF16_NEG_INF : BF16_POS_INF;
`endif
      end else if (w_e <= 10'sd0) begin
        o_err = ERR_UNF;
        o_sum = {w_big[15], 15'd0};
      end else begin
        o_sum = {w_big[15], w_e[7:0], w_man};
      end
    end
  end
endmodule

// File: rtl/bf16_mul_acc.sv
// bf16_mul_acc: sums each vector of bfloat16 products into one result with a
// sticky error code. ACCUM takes beats; HOLD presents the result until taken.
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_prod/in_err/in_last
// (product stream); out_valid/out_ready/out_sum/out_err/out_cnt (result).
// Macro BF16_MUL_ACC_SATURATE_EN (in bf16_add): saturate overflow to max finite.
module bf16_mul_acc
  import bf16_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic [1:0]       in_err,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] out_cnt
);
  state_t           r_state;
  logic [15:0]      r_acc;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      w_sum;
  logic [1:0]       w_add_err;
  logic [CNT_W-1:0] w_cnt_nxt;

  bf16_add u_add (
    .i_a   (r_acc),
    .i_b   (in_prod),
    .o_sum (w_sum),
    .o_err (w_add_err)
  );

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_acc;
  assign out_err   = r_err;
  assign out_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
      r_acc   <= 16'h0000;
      r_err   <= ERR_NONE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: if (in_valid) begin
          r_acc <= w_sum;
          r_err <= err_merge(err_merge(r_err, in_err), w_add_err);
          r_cnt <= w_cnt_nxt;
          if (in_last || (w_cnt_nxt == CNT_W'(MAX_LEN))) r_state <= ST_HOLD;
        end
        default: if (out_ready) begin
          r_acc   <= 16'h0000;
          r_err   <= ERR_NONE;
          r_cnt   <= '0;
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bf16_mul_acc.sv
// tb_bf16_mul_acc: directed vectors with hand-computed sums for bf16_mul_acc
// (built with MAX_LEN=4 so auto-termination is reachable).
module tb_bf16_mul_acc;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [15:0] in_prod, out_sum;
  logic [1:0]  in_err, out_err;
  logic [8:0]  out_cnt;
  int          n_chk = 0;
  int          n_bad = 0;

  bf16_mul_acc #(.MAX_LEN(4), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
    .in_err(in_err), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

`ifdef BF16_MUL_ACC_SATURATE_EN
  localparam logic [15:0] OVF_SUM = 16'h7F7F;
`else
  localparam logic [15:0] OVF_SUM = 16'h7F80;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic beat(input logic [15:0] p, input logic [1:0] e, input logic l);
    in_valid = 1'b1; in_prod = p; in_err = e; in_last = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("beat.rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_err = 2'd0;
  endtask

  // Called #1 after the last beat's edge: result must already be valid.
  task automatic result(input string tag, input logic [15:0] s, input logic [1:0] e, input int c);
    chk({tag, ".vld"}, out_valid, 1);
    chk({tag, ".sum"}, out_sum, s);
    chk({tag, ".err"}, out_err, e);
    chk({tag, ".cnt"}, out_cnt, c);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".clr"}, out_valid, 0);
    chk({tag, ".rdy"}, in_ready, 1);
  endtask

  task automatic vec2(input string tag, input logic [15:0] p0, input logic [1:0] e0,
                      input logic [15:0] p1, input logic [1:0] e1,
                      input logic [15:0] s, input logic [1:0] e);
    beat(p0, e0, 1'b0);
    beat(p1, e1, 1'b1);
    result(tag, s, e, 2);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_err = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", out_valid, 0);
    chk("rst.sum", out_sum, 16'h0000);
    chk("rst.err", out_err, 0);
    chk("rst.cnt", out_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.rdy", in_ready, 1);

    vec2("basic",  16'h3F80, 2'd0, 16'h4000, 2'd0, 16'h4040, 2'd0);
    vec2("cancel", 16'h3F80, 2'd0, 16'hBF80, 2'd0, 16'h0000, 2'd0);
    vec2("ovf",    16'h7F7F, 2'd0, 16'h7F7F, 2'd0, OVF_SUM,  2'd1);
    vec2("nan",    16'h3F80, 2'd2, 16'h7FC0, 2'd3, 16'h7FC0, 2'd3);
    vec2("prio",   16'h3F80, 2'd2, 16'h4000, 2'd1, 16'h4040, 2'd1);
    vec2("rne.tie",16'h3F80, 2'd0, 16'h3B80, 2'd0, 16'h3F80, 2'd0);
    vec2("rne.up", 16'h3F81, 2'd0, 16'h3B80, 2'd0, 16'h3F82, 2'd0);
    vec2("subin",  16'h3F80, 2'd0, 16'h0001, 2'd0, 16'h3F80, 2'd0);
    vec2("unf",    16'h0180, 2'd0, 16'h8170, 2'd0, 16'h0000, 2'd2);
    vec2("inf",    16'h7F80, 2'd0, 16'h3F80, 2'd0, 16'h7F80, 2'd0);
    vec2("infinf", 16'h7F80, 2'd0, 16'hFF80, 2'd0, 16'h7FC0, 2'd3);

    // invalid first, then an adder overflow: sticky stays 3
    beat(16'h3F80, 2'd3, 1'b0);
    beat(16'h7F7F, 2'd0, 1'b0);
    beat(16'h7F7F, 2'd0, 1'b1);
    result("sticky", OVF_SUM, 2'd3, 3);

    // MAX_LEN auto-termination
    for (int i = 0; i < 4; i++) beat(16'h3F80, 2'd0, 1'b0);
    result("maxlen", 16'h4080, 2'd0, 4);

    // back-pressure: a beat is offered but must not be taken while held
    beat(16'h3F80, 2'd0, 1'b0);
    beat(16'h3F80, 2'd0, 1'b1);
    in_valid = 1'b1; in_prod = 16'h4400; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.rdy", in_ready, 0);
      chk("bp.vld", out_valid, 1);
      chk("bp.sum", out_sum, 16'h4000);
      chk("bp.cnt", out_cnt, 2);
    end
    in_valid = 1'b0; in_last = 1'b0;
    result("bp", 16'h4000, 2'd0, 2);
    beat(16'h4000, 2'd0, 1'b1);
    result("bp.nxt", 16'h4000, 2'd0, 1);

    // reset while holding a result
    beat(16'h3F80, 2'd1, 1'b1);
    chk("rh.vld", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rh.vld0", out_valid, 0);
    chk("rh.sum", out_sum, 16'h0000);
    chk("rh.err", out_err, 0);
    chk("rh.cnt", out_cnt, 0);
    beat(16'h4000, 2'd0, 1'b1);
    result("rh.nxt", 16'h4000, 2'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
